// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and serial line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and shifts each word out as a UART frame.
//   state  | meaning
//   IDLE   | line high, waiting for enable and a non-empty FIFO
//   REQ    | one-cycle read strobe to the FIFO
//   LOAD   | capture registered FIFO data and its parity
//   START  | start bit
//   DATA   | data bits, LSB first
//   PARITY | even-parity bit (only when PARITY_EN)
//   STOP   | STOP_BITS stop bits; may chain straight into REQ
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    parity_q, parity_d;
    logic                    tx_q, tx_d;
    logic                    rd_q;
    logic                    bit_tick;
    logic                    timer_clear;
    logic                    start_ok;

    assign start_ok    = enable && !fifo_empty;
    assign timer_clear = (state_q == IDLE) || (state_q == REQ) || (state_q == LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        case (state_q)
            IDLE: if (start_ok) state_d = REQ;
            REQ:  state_d = LOAD;
            LOAD: begin
                shift_d  = fifo_dout;
                parity_d = ^fifo_dout;
                idx_d    = '0;
                state_d  = START;
            end
            START: if (bit_tick) begin
                idx_d   = '0;
                state_d = DATA;
            end
            DATA: if (bit_tick) begin
                if (idx_q == LAST_DATA) begin
                    idx_d   = '0;
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                end
            end
            PARITY: if (bit_tick) begin
                idx_d   = '0;
                state_d = STOP;
            end
            STOP: if (bit_tick) begin
                if (idx_q == LAST_STOP) begin
                    idx_d   = '0;
                    state_d = start_ok ? REQ : IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is decided from the upcoming state so tx comes straight from a flop.
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= IDLE_LEVEL;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            rd_q     <= (state_d == REQ);
        end
    end

    assign fifo_rd_en = rd_q;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign tx_done    = (state_q == STOP) && bit_tick && (idx_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E2, 4 clocks per bit) fed by FIFO models
// and compared cycle by cycle against a frame-level waveform model.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] en = 2'b00;
    logic [1:0] empty, rd, txw, busyw, donew;
    logic [7:0] dout [2];

    logic [7:0] mem [2][64];
    int rd_ptr [2] = '{0, 0};
    int wr_ptr [2] = '{0, 0};

    logic [3:0] log_v [2][0:DEPTH-1];   // {tx, rd_en, tx_done, busy}
    logic [3:0] exp_v [2][0:1023];
    logic [7:0] model_w [2][0:15];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(empty[0]), .fifo_dout(dout[0]),
        .fifo_rd_en(rd[0]), .tx(txw[0]), .busy(busyw[0]), .tx_done(donew[0]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(empty[1]), .fifo_dout(dout[1]),
        .fifo_rd_en(rd[1]), .tx(txw[1]), .busy(busyw[1]), .tx_done(donew[1]));

    assign empty[0] = (wr_ptr[0] == rd_ptr[0]);
    assign empty[1] = (wr_ptr[1] == rd_ptr[1]);

    // Registered-read FIFO: data appears the cycle after the strobe is seen.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd[k] && (wr_ptr[k] != rd_ptr[k])) begin
                dout[k]   <= mem[k][rd_ptr[k] % 64];
                rd_ptr[k] <= rd_ptr[k] + 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cyc < DEPTH) begin
            for (int k = 0; k < 2; k++) log_v[k][cyc] = {txw[k], rd[k], donew[k], busyw[k]};
        end
        cyc++;
    end

    task automatic push(input int k, input logic [7:0] w);
        mem[k][wr_ptr[k] % 64] = w;
        wr_ptr[k]++;
    endtask

    // Expected waveform for nw words sent back to back, starting from the REQ cycle.
    task automatic build_model(input int k, input int nw, input int ncyc);
        int pos, nb, par, stops;
        logic bv;
        par   = (k == 1) ? 1 : 0;
        stops = (k == 1) ? 2 : 1;
        nb    = 1 + 8 + par + stops;
        for (int i = 0; i < ncyc; i++) exp_v[k][i] = 4'b1000;
        pos = 0;
        for (int w = 0; w < nw; w++) begin
            if (pos + 1 < ncyc) begin
                exp_v[k][pos]     = 4'b1101;
                exp_v[k][pos + 1] = 4'b1001;
            end
            pos += 2;
            for (int b = 0; b < nb; b++) begin
                if (b == 0)                 bv = 1'b0;
                else if (b <= 8)            bv = (model_w[k][w] >> (b - 1)) & 8'd1;
                else if (par == 1 && b == 9) bv = ($countones(model_w[k][w]) % 2) == 1;
                else                        bv = 1'b1;
                for (int c = 0; c < CPB; c++) begin
                    if (pos < ncyc) exp_v[k][pos] = {bv, 1'b0, (b == nb - 1) && (c == CPB - 1), 1'b1};
                    pos++;
                end
            end
        end
    endtask

    function automatic int mism(input int k, input int base, input int n, input int f,
                                output int first, output logic act, output logic expv);
        int c = 0;
        first = -1; act = 1'b0; expv = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (log_v[k][base + i][f] !== exp_v[k][i][f]) begin
                if (c == 0) begin
                    first = i; act = log_v[k][base + i][f]; expv = exp_v[k][i][f];
                end
                c++;
            end
        end
        return c;
    endfunction

    function automatic string fname(input int f);
        case (f)
            3: return "tx";
            2: return "fifo_rd_en";
            1: return "tx_done";
            default: return "busy";
        endcase
    endfunction

    task automatic run(input logic [1:0] mask, input int ncyc, output int base);
        @(negedge clk);
        en   = mask;
        base = cyc;
        repeat (ncyc) @(posedge clk);
        #2;
        @(negedge clk);
        en = 2'b00;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (txw[k] !== 1'b1) begin errors++; $display("FAIL reset_tx dut%0d got %b want 1", k, txw[k]); end
            checks++; if (rd[k] !== 1'b0) begin errors++; $display("FAIL reset_rd_en dut%0d got %b want 0", k, rd[k]); end
            checks++; if (busyw[k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b want 0", k, busyw[k]); end
            checks++; if (donew[k] !== 1'b0) begin errors++; $display("FAIL reset_tx_done dut%0d got %b want 0", k, donew[k]); end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        int base, n, first; logic a, e;
        push(0, 8'hA5);
        model_w[0][0] = 8'hA5;
        run(2'b01, 50, base);
        build_model(0, 1, 50);
        for (int f = 0; f < 4; f++) begin
            n = mism(0, base, 50, f, first, a, e); checks++;
            if (n !== 0) begin errors++; $display("FAIL single_%s %0d cycles off, cycle %0d got %b want %b", fname(f), n, first, a, e); end
        end
    endtask

    task automatic test_back_to_back();
        int base, n, first; logic a, e;
        push(0, 8'h00); push(0, 8'hFF);
        model_w[0][0] = 8'h00; model_w[0][1] = 8'hFF;
        run(2'b01, 92, base);
        build_model(0, 2, 92);
        for (int f = 0; f < 4; f++) begin
            n = mism(0, base, 92, f, first, a, e); checks++;
            if (n !== 0) begin errors++; $display("FAIL b2b_%s %0d cycles off, cycle %0d got %b want %b", fname(f), n, first, a, e); end
        end
        checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL b2b_fifo_empty got %b want 1", empty[0]); end
    endtask

    task automatic test_parity_two_stop();
        int base, n, first; logic a, e;
        push(1, 8'h07);
        model_w[1][0] = 8'h07;
        run(2'b10, 56, base);
        build_model(1, 1, 56);
        for (int f = 0; f < 4; f++) begin
            n = mism(1, base, 56, f, first, a, e); checks++;
            if (n !== 0) begin errors++; $display("FAIL parity_%s %0d cycles off, cycle %0d got %b want %b", fname(f), n, first, a, e); end
        end
    endtask

    task automatic test_enable_gating();
        int base, n, first; logic a, e;
        push(0, 8'h3C);
        run(2'b00, 100, base);
        build_model(0, 0, 100);
        for (int f = 0; f < 4; f++) begin
            n = mism(0, base, 100, f, first, a, e); checks++;
            if (n !== 0) begin errors++; $display("FAIL gated_%s %0d cycles off, cycle %0d got %b want %b", fname(f), n, first, a, e); end
        end
        checks++; if (empty[0] !== 1'b0) begin errors++; $display("FAIL gated_fifo_kept got empty=%b want 0", empty[0]); end
        wr_ptr[0] = rd_ptr[0];
    endtask

    task automatic test_enable_drop();
        int base, n, first; logic a, e;
        model_w[0][0] = 8'($urandom); model_w[0][1] = 8'($urandom);
        push(0, model_w[0][0]); push(0, model_w[0][1]);
        @(negedge clk);
        en[0] = 1'b1;
        base  = cyc;
        repeat (20) @(negedge clk);
        en[0] = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        build_model(0, 1, 70);
        for (int f = 0; f < 4; f++) begin
            n = mism(0, base, 70, f, first, a, e); checks++;
            if (n !== 0) begin errors++; $display("FAIL drop_%s %0d cycles off, cycle %0d got %b want %b", fname(f), n, first, a, e); end
        end
        checks++; if (wr_ptr[0] - rd_ptr[0] !== 1) begin errors++; $display("FAIL drop_fifo_left got %0d words want 1", wr_ptr[0] - rd_ptr[0]); end
        wr_ptr[0] = rd_ptr[0];
    endtask

    task automatic test_empty_fifo();
        int base, n, first; logic a, e;
        run(2'b11, 100, base);
        for (int k = 0; k < 2; k++) begin
            build_model(k, 0, 100);
            for (int f = 0; f < 4; f++) begin
                n = mism(k, base, 100, f, first, a, e); checks++;
                if (n !== 0) begin errors++; $display("FAIL empty_dut%0d_%s %0d cycles off, cycle %0d got %b want %b", k, fname(f), n, first, a, e); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, n, first; logic a, e;
        logic [7:0] w2;
        model_w[0][0] = 8'($urandom);
        w2 = 8'($urandom);
        push(0, model_w[0][0]); push(0, w2);
        @(negedge clk);
        en[0] = 1'b1;
        base  = cyc;
        repeat (20) @(negedge clk);
        build_model(0, 1, 20);
        n = mism(0, base, 20, 1, first, a, e); checks++;
        if (n !== 0) begin errors++; $display("FAIL rstmid_prefix_tx_done %0d cycles off, cycle %0d got %b want %b", n, first, a, e); end
        n = mism(0, base, 20, 3, first, a, e); checks++;
        if (n !== 0) begin errors++; $display("FAIL rstmid_prefix_tx %0d cycles off, cycle %0d got %b want %b", n, first, a, e); end
        rst   = 1'b1;
        en[0] = 1'b0;
        #1;
        checks++; if (txw[0] !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", txw[0]); end
        checks++; if (busyw[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busyw[0]); end
        checks++; if (donew[0] !== 1'b0) begin errors++; $display("FAIL rstmid_tx_done got %b want 0", donew[0]); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_w[0][0] = w2;
        run(2'b01, 50, base);
        build_model(0, 1, 50);
        for (int f = 0; f < 4; f++) begin
            n = mism(0, base, 50, f, first, a, e); checks++;
            if (n !== 0) begin errors++; $display("FAIL rstmid_next_%s %0d cycles off, cycle %0d got %b want %b", fname(f), n, first, a, e); end
        end
    endtask

    task automatic test_random_back_to_back();
        int base, n, first, ncyc; logic a, e;
        int nw [2];
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 2; k++) begin
                nw[k] = $urandom_range(2, 4);
                for (int w = 0; w < nw[k]; w++) begin
                    model_w[k][w] = 8'($urandom);
                    push(k, model_w[k][w]);
                end
            end
            ncyc = 4 * (2 + 48) + 8;
            run(2'b11, ncyc, base);
            for (int k = 0; k < 2; k++) begin
                build_model(k, nw[k], ncyc);
                for (int f = 0; f < 4; f++) begin
                    n = mism(k, base, ncyc, f, first, a, e); checks++;
                    if (n !== 0) begin errors++; $display("FAIL rand%0d_dut%0d_%s %0d cycles off, cycle %0d got %b want %b", it, k, fname(f), n, first, a, e); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_parity_two_stop();
        test_enable_gating();
        test_enable_drop();
        test_empty_fifo();
        test_reset_mid_frame();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
